cube_root_ctrl: RTL

Sequential controller for the bit-serial integer cube root datapath. It accepts a 30-bit unsigned radicand and walks the 11 digit-selection steps. At each step it drives the partial result and step index to the downstream `Factor` stage, then consumes Factor's increment term `f = 3a²+3a+1` to decide one root bit. It also tracks the running remainder and reports the final root and remainder through a start/done handshake.

---
 rtl/cube_root_pkg.sv | 18 +
 rtl/cube_root_step.sv | 21 ++
 rtl/cube_root_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/cube_root_pkg.sv
// Shared constants, FSM state encoding and radicand group selection for the
// bit-serial cube root controller.
package cube_root_pkg;
    localparam int XW    = 30;
    localparam int STEPS = 11;
    localparam int REZW  = 11;
    localparam int XRW   = 3 * STEPS;
    localparam int RW    = 36;

    typedef enum logic [1:0] {IDLE, SETTLE, EVAL, DONE} state_t;

    // Three-bit radicand group consumed at step i: xr[35-3i : 33-3i].
    function automatic logic [2:0] grp(input logic [XRW-1:0] xr, input logic [3:0] i);
        logic [XRW-1:0] s;
        s = xr >> (XRW - 3 * int'(i));
        return s[2:0];
    endfunction
endpackage

// File: rtl/cube_root_step.sv
// One digit-selection step: shift in the next radicand group and subtract the
// Factor increment when it fits.
import cube_root_pkg::*;

module cube_root_step (
    input  logic [RW-1:0]  r,
    input  logic [2:0]     g,
    input  logic [XRW-1:0] f,
    output logic [RW-1:0]  r_nxt,
    output logic           acc
);
    logic [RW-1:0] t;
    logic [RW-1:0] fe;

    always_comb begin
        t     = (r << 3) | RW'(g);
        fe    = RW'(f);
        acc   = (t >= fe);
        r_nxt = acc ? (t - fe) : t;
    end
endmodule

// File: rtl/cube_root_ctrl.sv
// Sequential cube root controller: alternates SETTLE/EVAL per root bit while an
// external Factor stage supplies 3a^2+3a+1 for the current partial root.
import cube_root_pkg::*;

module cube_root_ctrl #(
    parameter int XW    = cube_root_pkg::XW,
    parameter int STEPS = cube_root_pkg::STEPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XW-1:0]        x,
    output logic                 busy,
    output logic                 done,
    output logic [XW/3-1:0]      root,
    output logic [31:0]          rem,
    output logic [3:0]           fac_i,
    output logic [STEPS-1:0]     fac_rez,
    input  logic [3*STEPS-1:0]   fac_f
);
    state_t          state, state_nxt;
    logic [XRW-1:0]  xr, xr_nxt;
    logic [RW-1:0]   r, r_nxt;
    logic [REZW-1:0] rez, rez_nxt;
    logic [3:0]      i, i_nxt;
    logic [2:0]      g;
    logic [RW-1:0]   step_r;
    logic            step_acc;

    cube_root_step u_step (
        .r     (r),
        .g     (g),
        .f     (fac_f),
        .r_nxt (step_r),
        .acc   (step_acc)
    );

    always_comb begin
        state_nxt = state;
        xr_nxt    = xr;
        r_nxt     = r;
        rez_nxt   = rez;
        i_nxt     = i;
        g         = grp(xr, i);
        case (state)
            IDLE: begin
                if (start) begin
                    xr_nxt    = XRW'(x);
                    r_nxt     = '0;
                    rez_nxt   = '0;
                    i_nxt     = 4'd1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: state_nxt = EVAL;
            EVAL: begin
                r_nxt = step_r;
                // Bit 11-i stays 0 until here so Factor sees a = 2 * decided prefix.
                if (step_acc) rez_nxt[4'(REZW) - i] = 1'b1;
                if (i == 4'(STEPS)) begin
                    state_nxt = DONE;
                end else begin
                    i_nxt     = i + 4'd1;
                    state_nxt = SETTLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            xr    <= '0;
            r     <= '0;
            rez   <= '0;
            i     <= '0;
        end else begin
            state <= state_nxt;
            xr    <= xr_nxt;
            r     <= r_nxt;
            rez   <= rez_nxt;
            i     <= i_nxt;
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            root  <= '0;
            rem   <= '0;
            fac_i <= '0;
        end else begin
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            fac_i <= (state_nxt == SETTLE || state_nxt == EVAL) ? i_nxt : 4'd0;
            if (state_nxt == DONE) begin
                root <= rez_nxt[XW/3-1:0];
                rem  <= r_nxt[31:0];
            end
        end
    end

    assign fac_rez = rez;
endmodule
